// File: rtl/uart_pkg.sv
// Shared UART receive-path constants and the stored entry layout.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 9
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: first-word-fall-through FIFO with sticky overrun and drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       WrValid,
  input  logic [DATA_W-1:0]          WrData,
  input  logic                       WrError,
  output logic                       RdValid,
  input  logic                       RdReady,
  output logic [DATA_W-1:0]          RdData,
  output logic                       RdError,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Overrun,
  output logic [7:0]                 DropCount,
  input  logic                       ClearOverrun
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             ovr_q, ovr_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             pop, wr_acc, drop;
  logic [DATA_W:0]  rd_entry;

  always_comb begin
    pop        = ~empty_q & RdReady;
    wr_acc     = WrValid & (~full_q | pop);
    drop       = WrValid & full_q & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovr_d      = ovr_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      ovr_d = 1'b1;
      if (ClearOverrun) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (ClearOverrun) begin
      ovr_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovr_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_W'(DEPTH));
      empty_q    <= (count_d == '0);
      ovr_q      <= ovr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 1)
  ) u_mem (
    .clk_i   (Clock),
    .we_i    (wr_acc & ~Reset),
    .waddr_i (wr_ptr_q),
    .wdata_i ({WrError, WrData}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign RdValid   = ~empty_q;
  assign RdData    = rd_entry[DATA_W-1:0];
  assign RdError   = rd_entry[DATA_W];
  assign Count     = count_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign Overrun   = ovr_q;
  assign DropCount = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle plus directed literals.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       Clock = 1'b0;
  logic       Reset, WrValid, WrError, RdReady, ClearOverrun;
  logic [7:0] WrData;
  logic       RdValid, RdError, Full, Empty, Overrun;
  logic [7:0] RdData, DropCount;
  logic [4:0] Count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit started   = 0;

  rx_entry_t m_q [$];
  bit        m_ovr = 0;
  int        m_dc  = 0;

  always #5 Clock = ~Clock;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .WrValid(WrValid), .WrData(WrData), .WrError(WrError),
    .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData), .RdError(RdError),
    .Count(Count), .Full(Full), .Empty(Empty), .Overrun(Overrun),
    .DropCount(DropCount), .ClearOverrun(ClearOverrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queue of entries, driven by the rules on the inputs.
  always @(posedge Clock) begin
    bit pop, full, wr, drop;
    rx_entry_t e;
    if (Reset) begin
      m_q.delete();
      m_ovr = 0;
      m_dc  = 0;
    end else begin
      pop  = (m_q.size() > 0) && RdReady;
      full = (m_q.size() == DEPTH);
      wr   = WrValid && (!full || pop);
      drop = WrValid && full && !pop;
      if (pop) void'(m_q.pop_front());
      if (wr) begin
        e.err  = WrError;
        e.data = WrData;
        m_q.push_back(e);
      end
      if (drop) begin
        m_ovr = 1;
        m_dc  = ClearOverrun ? 1 : (m_dc == 255 ? 255 : m_dc + 1);
      end else if (ClearOverrun) begin
        m_ovr = 0;
        m_dc  = 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      chk("RdValid", int'(RdValid), int'(m_q.size() > 0));
      chk("Count", int'(Count), m_q.size());
      chk("Full", int'(Full), int'(m_q.size() == DEPTH));
      chk("Empty", int'(Empty), int'(m_q.size() == 0));
      chk("Overrun", int'(Overrun), int'(m_ovr));
      chk("DropCount", int'(DropCount), m_dc);
      if (m_q.size() > 0) begin
        chk("RdData", int'(RdData), int'(m_q[0].data));
        chk("RdError", int'(RdError), int'(m_q[0].err));
      end
    end
  end

  task automatic cyc(input logic wv, input logic [7:0] d, input logic e,
                     input logic rr, input logic clr, input logic rst);
    WrValid = wv; WrData = d; WrError = e; RdReady = rr; ClearOverrun = clr; Reset = rst;
    @(posedge Clock);
    #1;
    WrValid = 0; RdReady = 0; ClearOverrun = 0; Reset = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic e);
    cyc(1'b1, d, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1; WrValid = 0; WrData = 0; WrError = 0; RdReady = 0; ClearOverrun = 0;
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1);
    started = 1;
    chk("rst_Count", int'(Count), 0);
    chk("rst_Empty", int'(Empty), 1);
    chk("rst_RdValid", int'(RdValid), 0);
    chk("rst_Overrun", int'(Overrun), 0);

    // Three bytes in, three out in order
    wr(8'h41, 0); wr(8'h42, 0); wr(8'h43, 0);
    chk("three_Count", int'(Count), 3);
    chk("three_RdData", int'(RdData), 8'h41);
    chk("three_RdValid", int'(RdValid), 1);
    pop1(); chk("pop_42", int'(RdData), 8'h42);
    pop1(); chk("pop_43", int'(RdData), 8'h43);
    pop1(); chk("drained_Empty", int'(Empty), 1);

    // RdReady while empty
    pop1(); chk("empty_pop_Count", int'(Count), 0);

    // Fill and overrun by two
    for (int i = 0; i < DEPTH; i++) wr(8'h80 + 8'(i), 0);
    wr(8'hF0, 0); wr(8'hF1, 0);
    chk("ovr_Full", int'(Full), 1);
    chk("ovr_Count", int'(Count), 16);
    chk("ovr_Overrun", int'(Overrun), 1);
    chk("ovr_DropCount", int'(DropCount), 2);
    chk("ovr_head", int'(RdData), 8'h80);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_Overrun", int'(Overrun), 0);
    chk("clr_DropCount", int'(DropCount), 0);

    // Write + pop while full
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullwp_Count", int'(Count), 16);
    chk("fullwp_Overrun", int'(Overrun), 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("fullwp_16th", int'(RdData), 8'h5A);
      pop1();
    end
    chk("fullwp_Empty", int'(Empty), 1);

    // Error flag passes through
    wr(8'h7E, 1);
    chk("err_RdError", int'(RdError), 1);
    chk("err_RdData", int'(RdData), 8'h7E);
    wr(8'h33, 0);
    pop1();
    chk("noerr_RdError", int'(RdError), 0);
    chk("noerr_RdData", int'(RdData), 8'h33);
    pop1();

    // Count==1 with simultaneous write and pop
    wr(8'h20, 0);
    cyc(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("c1_RdValid", int'(RdValid), 1);
    chk("c1_RdData", int'(RdData), 8'h10);
    chk("c1_Count", int'(Count), 1);
    pop1();

    // Drop counter saturation and clear-with-drop
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 0);
    for (int i = 0; i < 260; i++) wr(8'hEE, 0);
    chk("sat_DropCount", int'(DropCount), 255);
    cyc(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clrdrop_Overrun", int'(Overrun), 1);
    chk("clrdrop_DropCount", int'(DropCount), 1);

    // Count=5 with Overrun set, then reset alongside a write
    for (int i = 0; i < 11; i++) pop1();
    chk("pre_rst_Count", int'(Count), 5);
    chk("pre_rst_Overrun", int'(Overrun), 1);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_Count", int'(Count), 0);
    chk("midrst_Empty", int'(Empty), 1);
    chk("midrst_Overrun", int'(Overrun), 0);
    chk("midrst_RdValid", int'(RdValid), 0);

    // Streaming across pointer wrap
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(i * 7 + 3), 1'(i % 3 == 0), 1'(i > 0), 1'b0, 1'b0);
    chk("wrap_Count", int'(Count), 1);
    chk("wrap_last", int'(RdData), (39 * 7 + 3) & 8'hFF);
    pop1();
    chk("wrap_Empty", int'(Empty), 1);

    repeat (2) @(posedge Clock);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
